// File: rtl/ras_ckpt_if.sv
// ras_ckpt_if: bundles the return-address-stack push/pop, checkpoint and recovery signals.
// Latency: none. The interface is pure wiring.
// Backpressure: none. The RAS accepts push/pop/recover on every cycle.
//
// Modports:
//   master - branch predictor / FTQ side. Drives push/pop/recover and observes the stack state.
//   slave  - the ras_ckpt block itself.
interface ras_ckpt_if #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // predicted call / return
  logic              push;
  logic [ADDR_W-1:0] push_addr;
  logic              pop;

  // current top of stack and occupancy
  logic [ADDR_W-1:0] pop_addr;
  logic              pop_valid;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  // checkpoint taken alongside each predicted branch
  logic [PTR_W-1:0]  ckpt_ptr;
  logic [CNT_W-1:0]  ckpt_cnt;
  logic [ADDR_W-1:0] ckpt_top;

  // misprediction recovery
  logic              recover;
  logic [PTR_W-1:0]  recover_ptr;
  logic [CNT_W-1:0]  recover_cnt;
  logic [ADDR_W-1:0] recover_top;

  modport master (
    output push, push_addr, pop,
    output recover, recover_ptr, recover_cnt, recover_top,
    input  pop_addr, pop_valid, count, overflow,
    input  ckpt_ptr, ckpt_cnt, ckpt_top
  );

  modport slave (
    input  push, push_addr, pop,
    input  recover, recover_ptr, recover_cnt, recover_top,
    output pop_addr, pop_valid, count, overflow,
    output ckpt_ptr, ckpt_cnt, ckpt_top
  );
endinterface

// File: rtl/ras_ckpt.sv
// ras_ckpt: circular return address stack with full checkpoint/recovery for the fetch stage.
// Latency: the top-of-stack read is combinational (0 cycles). Push, pop and recover are visible the cycle after.
// Backpressure: none. Overflow overwrites the oldest entry, and underflow pops are silently dropped.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (clears pointer, occupancy and overflow; the array is left as is)
//   bus  - ras_ckpt_if.slave: push/pop, pop_addr/pop_valid/count/overflow, ckpt_* outputs, recover_* inputs
//
// Build option RAS_REPAIR_EN: when defined, recover also rewrites the checkpointed top slot
// from recover_top. This undoes a wrong-path push that landed on that slot after pops.
module ras_ckpt #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  ras_ckpt_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // The pointer arithmetic relies on the natural wrap of a PTR_W-bit counter.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ras_ckpt: DEPTH must be a power of two and at least 2");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] r_stack [DEPTH];
  logic [PTR_W-1:0]  r_wp;     // next free slot
  logic [CNT_W-1:0]  r_cnt;    // occupancy, 0..DEPTH
  logic              r_ovf;    // one-cycle pulse: a push landed while full

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic              w_nonempty;
  logic              w_full;
  logic [PTR_W-1:0]  w_top_ptr;
  logic [ADDR_W-1:0] w_top;

  assign w_nonempty = (r_cnt != '0);
  assign w_full     = (r_cnt == FULL_CNT);
  assign w_top_ptr  = r_wp - PTR_W'(1);
  // Stale array contents must never leak out while the stack is empty.
  assign w_top      = w_nonempty ? r_stack[w_top_ptr] : '0;

  // ---------------------------------------------------------------------------
  // Next-state decode (priority: recover > push/pop; rst is applied in the flops)
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]  w_wp_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_ovf_nxt;
  logic              w_wr_en;
  logic [PTR_W-1:0]  w_wr_idx;
  logic [ADDR_W-1:0] w_wr_dat;

  always_comb begin
    w_wp_nxt  = r_wp;
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_idx  = r_wp;
    w_wr_dat  = bus.push_addr;

    if (bus.recover) begin
      // Any push/pop in the same cycle belongs to the squashed path and is dropped.
      w_wp_nxt  = bus.recover_ptr;
      w_cnt_nxt = bus.recover_cnt;
`ifdef RAS_REPAIR_EN
      if (bus.recover_cnt != '0) begin
        w_wr_en  = 1'b1;
        w_wr_idx = bus.recover_ptr - PTR_W'(1);
        w_wr_dat = bus.recover_top;
      end
`endif
    end else if (bus.push && bus.pop && w_nonempty) begin
      // Call-and-return: the new return address replaces the top in place.
      w_wr_en  = 1'b1;
      w_wr_idx = w_top_ptr;
    end else if (bus.push) begin
      // Push only, or push+pop on an empty stack.
      // When full, the write slot is the oldest entry, so it is overwritten and the count saturates.
      w_wr_en   = 1'b1;
      w_wr_idx  = r_wp;
      w_wp_nxt  = r_wp + PTR_W'(1);
      w_cnt_nxt = w_full ? r_cnt : r_cnt + CNT_W'(1);
      w_ovf_nxt = w_full;
    end else if (bus.pop && w_nonempty) begin
      w_wp_nxt  = r_wp - PTR_W'(1);
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

`ifndef RAS_REPAIR_EN
  // Without repair, the saved top address has no consumer.
  logic w_unused_recover_top;
  assign w_unused_recover_top = ^bus.recover_top;
`endif

  // ---------------------------------------------------------------------------
  // Sequential update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_wp  <= w_wp_nxt;
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  // The storage array has no reset. Its contents are invisible until pushed.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      r_stack[w_wr_idx] <= w_wr_dat;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.pop_addr  = w_top;
  assign bus.pop_valid = w_nonempty;
  assign bus.count     = r_cnt;
  assign bus.overflow  = r_ovf;
  assign bus.ckpt_ptr  = r_wp;
  assign bus.ckpt_cnt  = r_cnt;
  assign bus.ckpt_top  = w_top;

endmodule

// File: tb/tb_ras_ckpt.sv
// tb_ras_ckpt: self-checking bench for ras_ckpt.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: none.
module tb_ras_ckpt;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
  localparam int PTR_W  = 4;
  localparam int CNT_W  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ras_ckpt_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();
  ras_ckpt #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard: expected stack contents, oldest first. Pushed when a push is driven,
  // and popped when the pop is checked against the DUT.
  logic [ADDR_W-1:0] sb[$];
  logic              m_ovf;
  int                m_wp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] exp_top();
    return (sb.size() != 0) ? sb[$] : '0;
  endfunction

  task automatic op(input logic p, input logic [ADDR_W-1:0] a, input logic q);
    bus.push = p; bus.push_addr = a; bus.pop = q;
    m_ovf = 1'b0;
    if (p && q && sb.size() != 0) begin
      void'(sb.pop_back());
      sb.push_back(a);
    end else if (p) begin
      if (sb.size() == DEPTH) begin
        void'(sb.pop_front());
        m_ovf = 1'b1;
      end
      sb.push_back(a);
      m_wp = (m_wp + 1) % DEPTH;
    end else if (q && sb.size() != 0) begin
      void'(sb.pop_back());
      m_wp = (m_wp + DEPTH - 1) % DEPTH;
    end
    tick();
    bus.push = 1'b0; bus.pop = 1'b0; bus.push_addr = '0;
  endtask

  task automatic do_recover(input logic [PTR_W-1:0] p, input logic [CNT_W-1:0] c,
                            input logic [ADDR_W-1:0] t, input logic with_push,
                            input logic [ADDR_W-1:0] pa);
    bus.recover = 1'b1; bus.recover_ptr = p; bus.recover_cnt = c; bus.recover_top = t;
    bus.push = with_push; bus.push_addr = pa;
    tick();
    bus.recover = 1'b0; bus.recover_ptr = '0; bus.recover_cnt = '0; bus.recover_top = '0;
    bus.push = 1'b0; bus.push_addr = '0;
    m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    m_ovf = 1'b0;
    m_wp = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_vec++; if (bus.pop_valid !== 1'b0) begin n_err++; $display("FAIL reset_pop_valid: got %b want 0", bus.pop_valid); end
    n_vec++; if (bus.pop_addr !== 32'h0) begin n_err++; $display("FAIL reset_pop_addr: got %h want 0", bus.pop_addr); end
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    n_vec++; if (bus.ckpt_ptr !== 4'd0) begin n_err++; $display("FAIL reset_ckpt_ptr: got %0d want 0", bus.ckpt_ptr); end
    n_vec++; if (bus.ckpt_cnt !== 5'd0) begin n_err++; $display("FAIL reset_ckpt_cnt: got %0d want 0", bus.ckpt_cnt); end
    n_vec++; if (bus.ckpt_top !== 32'h0) begin n_err++; $display("FAIL reset_ckpt_top: got %h want 0", bus.ckpt_top); end
  endtask

  task automatic test_push_pop();
    logic [ADDR_W-1:0] e;
    do_reset();
    op(1'b1, 32'h1000, 1'b0);
    op(1'b1, 32'h2000, 1'b0);
    n_vec++; if (bus.count !== 5'd2) begin n_err++; $display("FAIL pp_count2: got %0d want 2", bus.count); end
    n_vec++; if (bus.pop_valid !== 1'b1) begin n_err++; $display("FAIL pp_valid: got %b want 1", bus.pop_valid); end
    for (int k = 0; k < 2; k++) begin
      e = exp_top();
      n_vec++; if (bus.pop_addr !== e) begin n_err++; $display("FAIL pp_pop%0d_addr: got %h want %h", k, bus.pop_addr, e); end
      op(1'b0, '0, 1'b1);
      n_vec++; if (bus.count !== CNT_W'(sb.size())) begin n_err++; $display("FAIL pp_pop%0d_count: got %0d want %0d", k, bus.count, sb.size()); end
    end
    n_vec++; if (bus.pop_addr !== 32'h0) begin n_err++; $display("FAIL pp_empty_addr: got %h want 0", bus.pop_addr); end
    n_vec++; if (bus.pop_valid !== 1'b0) begin n_err++; $display("FAIL pp_empty_valid: got %b want 0", bus.pop_valid); end
    op(1'b0, '0, 1'b1);  // underflow is ignored
    n_vec++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL pp_underflow_count: got %0d want 0", bus.count); end
    n_vec++; if (bus.ckpt_ptr !== 4'd0) begin n_err++; $display("FAIL pp_underflow_ptr: got %0d want 0", bus.ckpt_ptr); end
  endtask

  task automatic test_overflow();
    logic [ADDR_W-1:0] e;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      op(1'b1, 32'h7000 + 32'(4 * i), 1'b0);
      n_vec++; if (bus.overflow !== m_ovf) begin n_err++; $display("FAIL ovf_push%0d: got %b want %b", i, bus.overflow, m_ovf); end
    end
    n_vec++; if (bus.count !== 5'd16) begin n_err++; $display("FAIL ovf_count: got %0d want 16", bus.count); end
    n_vec++; if (bus.ckpt_ptr !== 4'd1) begin n_err++; $display("FAIL ovf_ptr: got %0d want 1", bus.ckpt_ptr); end
    op(1'b0, '0, 1'b0);
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_pulse_width: got %b want 0", bus.overflow); end
    for (int k = 0; k < 16; k++) begin
      e = 32'h7040 - 32'(4 * k);
      n_vec++; if (bus.pop_addr !== e || sb[$] !== e) begin n_err++; $display("FAIL ovf_pop%0d: got %h want %h", k, bus.pop_addr, e); end
      op(1'b0, '0, 1'b1);
    end
    n_vec++; if (bus.pop_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got %b want 0", bus.pop_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    op(1'b1, 32'h1111, 1'b0);
    op(1'b1, 32'hAAAA, 1'b0);
    op(1'b1, 32'hBBBB, 1'b1);
    n_vec++; if (bus.count !== 5'd2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", bus.count); end
    n_vec++; if (bus.pop_addr !== 32'hBBBB) begin n_err++; $display("FAIL b2b_top: got %h want BBBB", bus.pop_addr); end
    op(1'b0, '0, 1'b1);
    n_vec++; if (bus.pop_addr !== 32'h1111) begin n_err++; $display("FAIL b2b_after_pop: got %h want 1111", bus.pop_addr); end
    // push+pop at full: replaces the top, no overflow, count stays DEPTH
    do_reset();
    for (int i = 0; i < DEPTH; i++) op(1'b1, 32'h100 + 32'(i), 1'b0);
    op(1'b1, 32'hCAFE, 1'b1);
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL b2b_full_ovf: got %b want 0", bus.overflow); end
    n_vec++; if (bus.count !== 5'd16) begin n_err++; $display("FAIL b2b_full_count: got %0d want 16", bus.count); end
    n_vec++; if (bus.pop_addr !== exp_top()) begin n_err++; $display("FAIL b2b_full_top: got %h want %h", bus.pop_addr, exp_top()); end
    // push+pop on empty behaves as a push
    do_reset();
    op(1'b1, 32'hD00D, 1'b1);
    n_vec++; if (bus.count !== 5'd1 || bus.pop_addr !== 32'hD00D) begin n_err++; $display("FAIL b2b_empty: got cnt %0d top %h want cnt 1 top D00D", bus.count, bus.pop_addr); end
  endtask

  task automatic test_recover();
    logic [ADDR_W-1:0] e;
    do_reset();
    op(1'b1, 32'h1000, 1'b0);
    op(1'b1, 32'h2000, 1'b0);
    n_vec++; if (bus.ckpt_ptr !== 4'd2 || bus.ckpt_cnt !== 5'd2 || bus.ckpt_top !== 32'h2000) begin
      n_err++; $display("FAIL rec_ckpt: got ptr %0d cnt %0d top %h want 2 2 2000", bus.ckpt_ptr, bus.ckpt_cnt, bus.ckpt_top);
    end
    op(1'b0, '0, 1'b1);
    op(1'b1, 32'h3000, 1'b0);
    op(1'b1, 32'h4000, 1'b0);
    do_recover(4'd2, 5'd2, 32'h2000, 1'b0, '0);
`ifdef RAS_REPAIR_EN
    e = 32'h2000;
`else
    e = 32'h3000;
`endif
    sb.delete(); sb.push_back(32'h1000); sb.push_back(e); m_wp = 2;
    n_vec++; if (bus.count !== 5'd2) begin n_err++; $display("FAIL rec_count: got %0d want 2", bus.count); end
    n_vec++; if (bus.ckpt_ptr !== 4'(m_wp)) begin n_err++; $display("FAIL rec_ptr: got %0d want %0d", bus.ckpt_ptr, m_wp); end
    n_vec++; if (bus.pop_addr !== e) begin n_err++; $display("FAIL rec_top: got %h want %h", bus.pop_addr, e); end
    op(1'b0, '0, 1'b1);
    n_vec++; if (bus.pop_addr !== 32'h1000) begin n_err++; $display("FAIL rec_next_pop: got %h want 1000", bus.pop_addr); end
  endtask

  task automatic test_recover_priority();
    do_reset();
    op(1'b1, 32'hA0, 1'b0);
    op(1'b1, 32'hB0, 1'b0);
    op(1'b1, 32'hC0, 1'b0);
    do_recover(4'd1, 5'd1, 32'hA0, 1'b1, 32'h9999);
    sb.delete(); sb.push_back(32'hA0); m_wp = 1;
    n_vec++; if (bus.count !== 5'd1) begin n_err++; $display("FAIL recp_count: got %0d want 1", bus.count); end
    n_vec++; if (bus.ckpt_ptr !== 4'd1) begin n_err++; $display("FAIL recp_ptr: got %0d want 1", bus.ckpt_ptr); end
    n_vec++; if (bus.pop_addr !== 32'hA0) begin n_err++; $display("FAIL recp_top: got %h want A0", bus.pop_addr); end
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL recp_ovf: got %b want 0", bus.overflow); end
    op(1'b1, 32'h1234, 1'b0);
    n_vec++; if (bus.count !== 5'd2 || bus.pop_addr !== 32'h1234) begin n_err++; $display("FAIL recp_push_after: got cnt %0d top %h want 2 1234", bus.count, bus.pop_addr); end
    n_vec++; if (bus.ckpt_ptr !== 4'(m_wp)) begin n_err++; $display("FAIL recp_ptr_after: got %0d want %0d", bus.ckpt_ptr, m_wp); end
  endtask

  task automatic test_reset_priority();
    do_reset();
    for (int i = 0; i < 5; i++) op(1'b1, 32'h50 + 32'(i), 1'b0);
    rst = 1'b1; bus.push = 1'b1; bus.push_addr = 32'hEEEE;
    tick();
    rst = 1'b0; bus.push = 1'b0; bus.push_addr = '0;
    sb.delete(); m_wp = 0; m_ovf = 1'b0;
    n_vec++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL rstp_count: got %0d want 0", bus.count); end
    n_vec++; if (bus.pop_valid !== 1'b0) begin n_err++; $display("FAIL rstp_valid: got %b want 0", bus.pop_valid); end
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL rstp_ovf: got %b want 0", bus.overflow); end
    op(1'b1, 32'h5000, 1'b0);
    n_vec++; if (bus.count !== 5'd1 || bus.pop_addr !== 32'h5000) begin n_err++; $display("FAIL rstp_push: got cnt %0d top %h want 1 5000", bus.count, bus.pop_addr); end
  endtask

  initial begin
    rst = 1'b1;
    bus.push = 1'b0; bus.push_addr = '0; bus.pop = 1'b0;
    bus.recover = 1'b0; bus.recover_ptr = '0; bus.recover_cnt = '0; bus.recover_top = '0;
    m_ovf = 1'b0; m_wp = 0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_back_to_back();
    test_recover();
    test_recover_priority();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ras_ckpt.md
Name: ras_ckpt

Overview:
- Parametrised successor to the core's return address stack.
- Sits in the fetch/branch-predict stage. Pushes the return address on a predicted call and supplies the predicted target on a predicted return.
- Circular storage: overflow overwrites the oldest entry instead of being lost.
- Handles push and pop in the same cycle (call-and-return).
- Exports a full checkpoint {write pointer, occupancy, top address}. On misprediction recovery this checkpoint restores the pointer, the occupancy and the corrupted top entry.

Parameters:
- DEPTH, 16, number of entries; must be a power of two, >= 2.
- ADDR_W, CPU_ADDR_BITS (32), return-address width.
- PTR_W, $clog2(DEPTH), write-pointer width (derived, not overridden).
- CNT_W, $clog2(DEPTH)+1, occupancy width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- push  in  1  predicted call: push push_addr
- push_addr  in  ADDR_W  return address to push
- pop  in  1  predicted return: pop top entry
- pop_addr  out  ADDR_W  current top entry; 0 when empty
- pop_valid  out  1  occupancy != 0
- count  out  CNT_W  occupancy, 0..DEPTH
- overflow  out  1  registered one-cycle pulse: a push landed while full
- ckpt_ptr  out  PTR_W  current write pointer
- ckpt_cnt  out  CNT_W  current occupancy
- ckpt_top  out  ADDR_W  current top entry (equals pop_addr)
- recover  in  1  restore state from recover_* inputs
- recover_ptr  in  PTR_W  saved write pointer
- recover_cnt  in  CNT_W  saved occupancy
- recover_top  in  ADDR_W  saved top entry

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - wp=0, count=0, overflow=0, pop_valid=0, pop_addr=0, ckpt_*=0.
  - Storage array is not cleared; its contents are invisible while empty.
- Storage and read path:
  - wp points to the next free slot; top slot = wp-1 modulo DEPTH.
  - pop_addr = stack[wp-1] when count != 0, else 0. The read is combinational from registers, so latency is 0.
- Write/update latency: push, pop and recover take effect at the next posedge and are visible the cycle after.
- Priority: rst > recover > push/pop.
- recover:
  - wp <= recover_ptr; count <= recover_cnt.
  - Repair write per RAS_REPAIR_EN (see below).
  - push and pop in the same cycle are ignored; overflow <= 0.
- push only:
  - stack[wp] <= push_addr; wp <= wp+1, wrapping DEPTH-1 -> 0.
  - count <= min(count+1, DEPTH).
  - overflow <= 1 iff count == DEPTH before the push.
- pop only:
  - If count != 0: wp <= wp-1 (wrapping 0 -> DEPTH-1); count <= count-1.
  - If count == 0: no state change. Underflow is silently ignored.
- push and pop together:
  - If count != 0: stack[wp-1] <= push_addr; wp and count unchanged; overflow <= 0.
  - If count == 0: behaves as push only.
- overflow deasserts on every cycle that is not a push-only cycle at full.
- Wrap-around: after overflow, the DEPTH most recent pushes are retained; older entries are lost.
- Checkpoint outputs: ckpt_ptr=wp, ckpt_cnt=count, ckpt_top=pop_addr. All are combinational from current registers; the owner (FTQ/ROB) samples them alongside the branch.
- recover_cnt > DEPTH is illegal; behaviour is undefined and the bench must not drive it.

Optional Feature:
- Macro: RAS_REPAIR_EN.
- With the macro defined: on recover with recover_cnt != 0, stack[recover_ptr-1] <= recover_top in the same cycle. This undoes a wrong-path push that overwrote the checkpointed top slot after pops.
- Without the macro: recover restores only wp and count. recover_top is unused, and the top entry may hold wrong-path data.

Test Plan:
1. Reset, then push 0x1000, push 0x2000 -> count=2, pop_valid=1, pop_addr=0x2000. Pop -> pop_addr=0x1000, count=1. Pop -> count=0, pop_addr=0, pop_valid=0. Extra pop -> count stays 0.
2. Reset, then 17 pushes of 0x7000+4i (i=0..16) -> overflow pulses for exactly one cycle after the 17th push; count=16. Sixteen pops return 0x7040 down to 0x7004, then pop_valid=0.
3. Push 0x1111, push 0xAAAA; next cycle push=pop=1 with push_addr=0xBBBB -> count=2, pop_addr=0xBBBB. Pop -> pop_addr=0x1111.
4. Push 0x1000, push 0x2000; sample checkpoint (ptr=2, cnt=2, top=0x2000). Pop, push 0x3000, push 0x4000, then recover with the sample -> count=2, ckpt_ptr=2. pop_addr=0x2000 with RAS_REPAIR_EN, 0x3000 without. Next pop -> 0x1000.
5. From count=3, drive recover (ptr=1, cnt=1) together with push=1 (0x9999) -> count=1, ckpt_ptr=1; 0x9999 is not pushed.
6. Push 5 entries, then assert rst together with push=1 -> count=0, pop_valid=0, overflow=0. A following push of 0x5000 -> count=1, pop_addr=0x5000.
